// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the BCD operand sequencer.
// Segment patterns are active-low; bit 7 is the decimal point, bits 6:0 are g..a.
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        StLoadA   = 2'd0,
        StLoadB   = 2'd1,
        StCapture = 2'd2,
        StShow    = 2'd3
    } seq_state_e;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_operand_sequencer_if.sv
// Switch/key inputs, adder connections and display outputs of the sequencer.
interface bcd_operand_sequencer_if;
    logic       key_n;
    logic [3:0] sw_digit;
    logic       sw_cin;
    logic [3:0] sum_in;
    logic       cout_in;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [1:0] state_o;
    logic       err;
    logic       result_valid;
    logic [7:0] hex0;
    logic [7:0] hex1;

    modport master (
        output key_n, sw_digit, sw_cin, sum_in, cout_in,
        input  a, b, cin, state_o, err, result_valid, hex0, hex1
    );

    modport slave (
        input  key_n, sw_digit, sw_cin, sum_in, cout_in,
        output a, b, cin, state_o, err, result_valid, hex0, hex1
    );
endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low key; emits a one-cycle press pulse
// on each accepted 1->0 transition of the stable level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      sync_q;
    logic            stable_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    // The new level is adopted on the edge after the count reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_operand_sequencer.sv
// Collects operand A, then B and carry-in, one per debounced key press; feeds the
// external BCD adder, captures its result and shows it on two 7-segment digits.
module bcd_operand_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input logic                     clk,
    input logic                     reset,
    bcd_operand_sequencer_if.slave  bus
);

    seq_state_e state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       cin_q;
    logic       err_q;
    logic       result_valid_q;
    logic [4:0] result_q;
    logic       press;
    logic       digit_ok;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .reset (reset),
        .key_n (bus.key_n),
        .press (press)
    );

    assign digit_ok = (bus.sw_digit <= BCD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StLoadA;
            a_q            <= '0;
            b_q            <= '0;
            cin_q          <= 1'b0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            unique case (state_q)
                StLoadA: begin
                    if (press) begin
                        if (digit_ok) begin
                            a_q     <= bus.sw_digit;
                            err_q   <= 1'b0;
                            state_q <= StLoadB;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StLoadB: begin
                    if (press) begin
                        if (digit_ok) begin
                            b_q     <= bus.sw_digit;
                            cin_q   <= bus.sw_cin;
                            err_q   <= 1'b0;
                            state_q <= StCapture;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // One full cycle for the adder to settle on the new b/cin.
                StCapture: begin
                    result_q       <= {bus.cout_in, bus.sum_in};
                    result_valid_q <= 1'b1;
                    state_q        <= StShow;
                end
                StShow: begin
                    if (press) begin
                        result_valid_q <= 1'b0;
                        state_q        <= StLoadA;
                    end
                end
            endcase
        end
    end

    // Display is decoded purely from registers; result_valid is only set in StShow.
    always_comb begin
        bus.hex0 = SEG_BLANK;
        bus.hex1 = SEG_BLANK;
        if (result_valid_q) begin
            bus.hex0 = bcd_to_seg(result_q[3:0]);
            if (result_q[4]) begin
                bus.hex1 = bcd_to_seg(4'd1);
            end
        end
    end

    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.cin          = cin_q;
    assign bus.state_o      = state_q;
    assign bus.err          = err_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
// Self-checking bench: behavioural BCD adder in the loop, reference model feeding
// a scoreboard of expected output snapshots.
module tb_bcd_operand_sequencer;

    localparam int unsigned DB = 4;

    typedef struct {
        logic [1:0] state;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       err;
        logic       rv;
        logic [7:0] hex0;
        logic [7:0] hex1;
    } snap_t;

    logic clk;
    logic reset;
    logic bad_sum;
    int   n_vec;
    int   n_miss;
    snap_t m;
    snap_t sb[$];

    bcd_operand_sequencer_if bus ();

    bcd_operand_sequencer #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural one-digit BCD adder; bad_sum forces an out-of-range sum.
    logic [4:0] raw;
    logic [3:0] add_s;
    logic       add_c;
    always_comb begin
        raw   = 5'(bus.a) + 5'(bus.b) + 5'(bus.cin);
        add_c = 1'b0;
        add_s = raw[3:0];
        if (raw > 5'd9) begin
            add_c = 1'b1;
            add_s = 4'(raw - 5'd10);
        end
    end
    assign bus.sum_in  = bad_sum ? 4'hC : add_s;
    assign bus.cout_in = bad_sum ? 1'b0 : add_c;

    function automatic logic [7:0] tb_seg(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'h86;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m.state = 2'd0;
        m.a     = 4'd0;
        m.b     = 4'd0;
        m.cin   = 1'b0;
        m.err   = 1'b0;
        m.rv    = 1'b0;
        m.hex0  = 8'hFF;
        m.hex1  = 8'hFF;
    endtask

    task automatic model_press(input int d, input logic c);
        int tot;
        int s;
        logic co;
        case (m.state)
            2'd0: begin
                if (d <= 9) begin
                    m.a = 4'(d); m.err = 1'b0; m.state = 2'd1;
                end else begin
                    m.err = 1'b1;
                end
            end
            2'd1: begin
                if (d <= 9) begin
                    m.b = 4'(d); m.cin = c; m.err = 1'b0;
                    tot = int'(m.a) + d + int'(c);
                    if (bad_sum) begin
                        s = 12; co = 1'b0;
                    end else if (tot > 9) begin
                        s = tot - 10; co = 1'b1;
                    end else begin
                        s = tot; co = 1'b0;
                    end
                    m.rv    = 1'b1;
                    m.hex0  = tb_seg(s);
                    m.hex1  = co ? 8'hF9 : 8'hFF;
                    m.state = 2'd3;
                end else begin
                    m.err = 1'b1;
                end
            end
            default: begin
                m.rv = 1'b0; m.hex0 = 8'hFF; m.hex1 = 8'hFF; m.state = 2'd0;
            end
        endcase
    endtask

    task automatic check_snap(input string tag);
        snap_t e;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, ".state"}, 32'(bus.state_o), 32'(e.state));
        check_eq({tag, ".a"}, 32'(bus.a), 32'(e.a));
        check_eq({tag, ".b"}, 32'(bus.b), 32'(e.b));
        check_eq({tag, ".cin"}, 32'(bus.cin), 32'(e.cin));
        check_eq({tag, ".err"}, 32'(bus.err), 32'(e.err));
        check_eq({tag, ".rv"}, 32'(bus.result_valid), 32'(e.rv));
        check_eq({tag, ".hex0"}, 32'(bus.hex0), 32'(e.hex0));
        check_eq({tag, ".hex1"}, 32'(bus.hex1), 32'(e.hex1));
    endtask

    // Key low for low_cycles; checks the press lands exactly DB+3 edges after edge k.
    task automatic do_press(input int d, input logic c, input int low_cycles, input string tag);
        logic [1:0] pre;
        logic [1:0] mid;
        pre = m.state;
        model_press(d, c);
        mid = (pre == 2'd1 && d <= 9) ? 2'd2 : m.state;
        sb.push_back(m);
        @(negedge clk);
        bus.sw_digit = 4'(d);
        bus.sw_cin   = c;
        bus.key_n    = 1'b0;
        fork
            begin
                repeat (low_cycles) @(negedge clk);
                bus.key_n = 1'b1;
            end
            begin
                @(posedge clk);
                repeat (DB + 2) @(posedge clk);
                #1 check_eq({tag, ".early"}, 32'(bus.state_o), 32'(pre));
                @(posedge clk);
                #1 check_eq({tag, ".edge"}, 32'(bus.state_o), 32'(mid));
                @(posedge clk);
                #1 check_snap(tag);
            end
        join
        repeat (DB + 6) @(posedge clk);
        sb.push_back(m);
        #1 check_snap({tag, ".release"});
    endtask

    task automatic glitch(input int low_cycles, input string tag);
        sb.push_back(m);
        @(negedge clk);
        bus.key_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        bus.key_n = 1'b1;
        repeat (DB + 8) @(posedge clk);
        #1 check_snap(tag);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        reset        = 1'b1;
        bad_sum      = 1'b0;
        bus.key_n    = 1'b1;
        bus.sw_digit = 4'd0;
        bus.sw_cin   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(m);
        @(posedge clk);
        #1 check_snap("reset");

        do_press(7, 1'b0, 10, "a7");
        do_press(5, 1'b1, 10, "b5c1");
        do_press(0, 1'b0, 10, "wrap");
        do_press(0, 1'b0, 10, "a0");
        do_press(0, 1'b0, 10, "b0");
        do_press(0, 1'b0, 10, "wrap2");
        do_press(12, 1'b0, 10, "ill_a");
        do_press(4, 1'b0, 10, "a4");
        glitch(3, "glitch");
        do_press(11, 1'b1, 10, "ill_b");
        bad_sum = 1'b1;
        do_press(3, 1'b0, 10, "bad_sum");
        bad_sum = 1'b0;
        do_press(0, 1'b0, 10, "wrap3");
        do_press(9, 1'b0, 10, "a9");

        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        sb.push_back(m);
        #1 check_snap("areset");
        @(negedge clk);
        reset = 1'b0;

        do_press(3, 1'b0, 50, "held");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_operand_sequencer.md
# bcd_operand_sequencer

Sequential front/back end for the combinational one-digit BCD adder on the DE10-Lite. It takes one switch-selected digit per debounced key press: operand A, then operand B with carry-in. It drives the adder's `a`/`b`/`cin` inputs, then captures the adder's `s`/`cout` into a result register. The registered result is shown as two decimal digits on active-low 7-segment outputs.

## Interface
- `DEBOUNCE_CYCLES`, default 500000 — consecutive stable samples required to accept a key level change; 10 ms at 50 MHz.
- `clk`  in  1 — system clock, driven from `MAX10_CLK1_50` at top level.
- `reset`  in  1 — asynchronous, active-high; one clock domain only.
- `key_n`  in  1 — raw pushbutton, active-low, asynchronous to `clk`.
- `sw_digit`  in  4 — digit being entered; legal range 0..9.
- `sw_cin`  in  1 — carry-in value, latched together with operand B.
- `sum_in`  in  4 — adder `s`.
- `cout_in`  in  1 — adder `cout`.
- `a`  out  4 — registered operand A to the adder.
- `b`  out  4 — registered operand B to the adder.
- `cin`  out  1 — registered carry-in to the adder.
- `state_o`  out  2 — current state code, for LEDs.
- `err`  out  1 — last entry attempt was an illegal digit.
- `result_valid`  out  1 — result registers hold a captured sum.
- `hex0`  out  8 — ones digit, active-low; bit 7 is the decimal point.
- `hex1`  out  8 — tens digit, active-low; bit 7 is the decimal point.

## Operation
- **Reset values:**
  - FSM is in LOAD_A, `state_o`=0.
  - `a`=0, `b`=0, `cin`=0, `err`=0, `result_valid`=0.
  - `hex0`=`hex1`=8'hFF (blank).
  - Debouncer stable level is 1; its counter is 0.
- **Debouncer:**
  - 2-flop synchronizer on `key_n`.
  - The counter increments while the synchronized level differs from the stable level, and clears to 0 whenever they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level takes the new value and the counter clears.
  - A stable 1→0 transition produces a `press` pulse that is high for exactly one cycle. Release produces no event.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no event.
- **FSM states (`state_o` codes):**
  - **LOAD_A (0):**
    - On `press` with `sw_digit`≤9: `a`←`sw_digit`, `err`←0, go to LOAD_B.
    - On `press` with `sw_digit`≥10: `err`←1, stay in LOAD_A, `a` unchanged.
  - **LOAD_B (1):**
    - On `press` with a legal digit: `b`←`sw_digit`, `cin`←`sw_cin`, `err`←0, go to CAPTURE.
    - On `press` with an illegal digit: `err`←1, stay in LOAD_B.
  - **CAPTURE (2):**
    - Unconditional, lasts one cycle; gives the combinational adder one full cycle to settle on the new `b`/`cin`.
    - Captures `result`←{`cout_in`,`sum_in`}, sets `result_valid`←1, goes to SHOW.
  - **SHOW (3):**
    - `hex0` = 7-segment decode of `sum_in` as captured (digit 0..9).
    - `hex1` = decode of the captured cout: "1" if set, blank if clear (no leading zero).
    - On `press`: `result_valid`←0, `hex0`/`hex1`←blank, go to LOAD_A.
    - `a`, `b`, `cin` are retained until overwritten.
- **Outside SHOW:** `hex0`/`hex1` are blank.
- **Illegal captured sum:** if the adder returns `sum_in`>9, `hex0` shows the "E" pattern. `result_valid` still asserts.
- **`press` in CAPTURE:** cannot be lost. Each `press` is followed by at least `DEBOUNCE_CYCLES`≥2 cycles without another press, so CAPTURE never coincides with a press that matters. If `DEBOUNCE_CYCLES`<2, a press in CAPTURE is ignored.
- **Reset mid-operation:** returns immediately to the reset values and abandons any partial entry.

## Timing
- `key_n` is first sampled low at edge k. The stable level changes at edge k+2+`DEBOUNCE_CYCLES`. `press` is high during the following cycle, and the FSM acts on it at edge k+3+`DEBOUNCE_CYCLES`.
- The operand registers update on the same edge as the FSM transition that consumes `press`.
- B accepted at edge t: capture at edge t+1; `result_valid` and `hex0`/`hex1` valid after edge t+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `bcd_seq_pkg` holds:
  - the state enum with its 2-bit encoding (LOAD_A=0, LOAD_B=1, CAPTURE=2, SHOW=3);
  - `BCD_MAX`=9;
  - `SEG_BLANK`=8'hFF and `SEG_E`;
  - a function `bcd_to_seg(4-bit) → 8-bit` that returns active-low segments with the decimal point off, and `SEG_E` for inputs >9.
- Sub-module `key_debounce`, parameterized by `DEBOUNCE_CYCLES`: synchronizer, counter, stable register and `press` pulse.
- The FSM and datapath stay in `bcd_operand_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a behavioural BCD adder model in the loop.
- **Normal entry:** reset; press with `sw_digit`=7, then press with `sw_digit`=5 and `sw_cin`=1 → `a`=7, `b`=5, `cin`=1. The cycle after B is accepted: `result_valid`=1, `hex1`="1", `hex0`="3", `state_o`=3.
- **Illegal digit:** in LOAD_A press with `sw_digit`=12 → `err`=1, `state_o`=0, `a`=0. Then press with `sw_digit`=4 → `err`=0, `a`=4, `state_o`=1.
- **Debounce:** a 3-cycle low glitch on `key_n` → no `press`, no state change. A 10-cycle low pulse → exactly one `press`, `DEBOUNCE_CYCLES`+3 edges after the first low sample.
- **Wrap-around:** press in SHOW → `result_valid`=0, `hex0`=`hex1`=8'hFF, `state_o`=0. Entering 0 + 0 with `cin`=0 gives `hex0`="0" and `hex1` blank.
- **Asynchronous reset in LOAD_B:** assert `reset` between clock edges with `a`=9 loaded → `a`, `b`, `cin`, `err`, `result_valid` all 0 and `state_o`=0 immediately, without waiting for a clock edge.
- **Held key:** hold `key_n` low for 50 cycles → exactly one state advance.
